// File: rtl/fifo_rd_stream_pkg.sv
// Shared types and default sizing for the fifo read-side stream adapter.
package fifo_rd_stream_pkg;

  // State value doubles as skid-buffer occupancy.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam int DEF_DSIZE = 8;
  localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/fifo_rd_stream_if.sv
// Valid/ready output stream carrying fifo words downstream.
interface fifo_rd_stream_if #(parameter int DSIZE = 8);
  logic [DSIZE-1:0] m_data;
  logic             m_valid;
  logic             m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/fifo_rd_stream_sat_counter.sv
// Event counter with synchronous clear and optional saturation at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         inc,
  input  logic         sat_en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (inc && !(sat_en && (count == '1)))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/fifo_rd_stream.sv
// Pops the dual-clock fifo read port into a 2-entry skid buffer and presents
// words on a registered valid/ready stream; flush drains and discards.
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int DSIZE = DEF_DSIZE,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic [DSIZE-1:0]    fifo_rdata,
  input  logic                fifo_rempty,
  output logic                fifo_rinc,
  fifo_rd_stream_if.master    m,
  input  logic                flush,
  output logic [1:0]          occ,
  output logic [CNT_W-1:0]    rd_count,
  output logic [CNT_W-1:0]    drop_count
);

  state_t           state_q, state_d;
  logic [DSIZE-1:0] head_q, head_d;
  logic [DSIZE-1:0] skid_q, skid_d;
  logic             valid_q;
  logic             pop_out;
  logic             push;

  assign pop_out   = valid_q & m.m_ready;
  // Gated by rrst_n so the fifo is never popped while held in reset.
  assign fifo_rinc = rrst_n & ~fifo_rempty & (flush | (state_q != TWO));
  assign push      = fifo_rinc & ~flush;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: if (push) begin
          state_d = ONE;
          head_d  = fifo_rdata;
        end
        ONE: begin
          if (push && pop_out) begin
            head_d = fifo_rdata;
          end else if (push) begin
            state_d = TWO;
            skid_d  = fifo_rdata;
          end else if (pop_out) begin
            state_d = EMPTY;
          end
        end
        TWO: if (pop_out) begin
          state_d = ONE;
          head_d  = skid_q;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
      valid_q <= (state_d != EMPTY);
    end
  end

  assign m.m_data  = head_q;
  assign m.m_valid = valid_q;
  assign occ       = state_q;

  // Handshakes coinciding with flush still count as delivered.
  sat_counter #(.W(CNT_W)) u_rd_cnt (
    .clk    (rclk),
    .rst_n  (rrst_n),
    .clear  (1'b0),
    .inc    (pop_out),
    .sat_en (1'b0),
    .count  (rd_count)
  );

  sat_counter #(.W(CNT_W)) u_drop_cnt (
    .clk    (rclk),
    .rst_n  (rrst_n),
    .clear  (1'b0),
    .inc    (fifo_rinc & flush),
    .sat_en (1'b1),
    .count  (drop_count)
  );

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench for fifo_rd_stream: a queue models the fifo, a second
// queue holds the expected output order.
module tb_fifo_rd_stream;

  logic        rclk = 1'b0;
  logic        rrst_n = 1'b0;
  logic [7:0]  fifo_rdata = '0;
  logic        fifo_rempty = 1'b1;
  logic        fifo_rinc;
  logic        flush = 1'b0;
  logic [1:0]  occ;
  logic [15:0] rd_count, drop_count;

  logic        fifo_rempty4 = 1'b1;
  logic        fifo_rinc4;
  logic        flush4 = 1'b0;
  logic [1:0]  occ4;
  logic [3:0]  rd_count4, drop_count4;

  fifo_rd_stream_if #(.DSIZE(8)) sif ();
  fifo_rd_stream_if #(.DSIZE(8)) sif4 ();

  fifo_rd_stream #(.DSIZE(8), .CNT_W(16)) dut (
    .rclk        (rclk),
    .rrst_n      (rrst_n),
    .fifo_rdata  (fifo_rdata),
    .fifo_rempty (fifo_rempty),
    .fifo_rinc   (fifo_rinc),
    .m           (sif),
    .flush       (flush),
    .occ         (occ),
    .rd_count    (rd_count),
    .drop_count  (drop_count)
  );

  fifo_rd_stream #(.DSIZE(8), .CNT_W(4)) dut4 (
    .rclk        (rclk),
    .rrst_n      (rrst_n),
    .fifo_rdata  (8'h3c),
    .fifo_rempty (fifo_rempty4),
    .fifo_rinc   (fifo_rinc4),
    .m           (sif4),
    .flush       (flush4),
    .occ         (occ4),
    .rd_count    (rd_count4),
    .drop_count  (drop_count4)
  );

  always #5 rclk = ~rclk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  logic [7:0]  fq[$];
  logic [7:0]  exp_q[$];
  logic        pop_pend = 1'b0;
  logic        hold = 1'b0;
  logic        flush_prev = 1'b0;
  logic [7:0]  held = '0;
  int unsigned rinc_cnt = 0;
  int unsigned hs4 = 0;

  // Fifo model: pop decided from pre-edge rinc, flags refreshed just after the edge.
  always @(posedge rclk) begin
    #1;
    if (pop_pend && fq.size() > 0) void'(fq.pop_front());
    fifo_rempty = (fq.size() == 0);
    fifo_rdata  = (fq.size() > 0) ? fq[0] : 8'h00;
  end

  always @(negedge rclk) begin
    pop_pend = rrst_n && fifo_rinc;
    if (rrst_n) begin
      if (hold && !flush_prev) begin
        check_eq("hold_valid", 32'(sif.m_valid), 32'd1);
        check_eq("hold_data", 32'(sif.m_data), 32'(held));
      end
      if (sif.m_valid && sif.m_ready) begin
        if (exp_q.size() == 0)
          check_eq("sb_nonempty", 32'(exp_q.size()), 32'd1);
        else
          check_eq("out_data", 32'(sif.m_data), 32'(exp_q.pop_front()));
      end
      hold       = sif.m_valid & ~sif.m_ready;
      held       = sif.m_data;
      flush_prev = flush;
      if (fifo_rinc) rinc_cnt++;
      if (sif4.m_valid && sif4.m_ready) hs4++;
    end
  end

  task automatic cyc(input int unsigned n);
    repeat (n) begin
      @(posedge rclk);
      #2;
    end
  endtask

  task automatic put(input logic [7:0] w);
    fq.push_back(w);
    exp_q.push_back(w);
  endtask

  logic        pat[5];
  int unsigned base;
  int unsigned n4;

  initial begin
    sif.m_ready  = 1'b1;
    sif4.m_ready = 1'b1;
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    // Reset held with a non-empty fifo
    for (int i = 1; i <= 15; i++) put(8'(i));
    cyc(3);
    check_eq("rst_rinc", 32'(fifo_rinc), 32'd0);
    check_eq("rst_valid", 32'(sif.m_valid), 32'd0);
    check_eq("rst_data", 32'(sif.m_data), 32'd0);
    check_eq("rst_occ", 32'(occ), 32'd0);
    check_eq("rst_rd_count", 32'(rd_count), 32'd0);
    check_eq("rst_drop_count", 32'(drop_count), 32'd0);
    rrst_n = 1'b1;
    #1;
    check_eq("rel_rinc", 32'(fifo_rinc), 32'd1);

    // Streaming
    cyc(1);
    check_eq("first_valid", 32'(sif.m_valid), 32'd1);
    check_eq("first_data", 32'(sif.m_data), 32'h01);
    cyc(16);
    check_eq("stream_rd_count", 32'(rd_count), 32'd15);
    check_eq("stream_drained", 32'(exp_q.size()), 32'd0);
    check_eq("stream_valid_drop", 32'(sif.m_valid), 32'd0);

    // Backpressure
    sif.m_ready = 1'b0;
    base = rinc_cnt;
    for (int i = 1; i <= 5; i++) put(8'(i));
    cyc(10);
    check_eq("bp_rinc_pulses", rinc_cnt - base, 32'd2);
    check_eq("bp_occ", 32'(occ), 32'd2);
    check_eq("bp_data", 32'(sif.m_data), 32'h01);
    check_eq("bp_rinc_low", 32'(fifo_rinc), 32'd0);
    sif.m_ready = 1'b1;
    cyc(10);
    check_eq("bp_drained", 32'(exp_q.size()), 32'd0);
    check_eq("bp_rd_count", 32'(rd_count), 32'd20);

    // Toggling ready
    for (int i = 0; i < 5; i++) put(8'h10 + 8'(i));
    cyc(1);
    for (int i = 0; i < 5; i++) begin
      sif.m_ready = pat[i];
      cyc(1);
    end
    sif.m_ready = 1'b1;
    cyc(8);
    check_eq("tog_drained", 32'(exp_q.size()), 32'd0);
    check_eq("tog_rd_count", 32'(rd_count), 32'd25);

    // Flush with a full buffer and four words left in the fifo
    sif.m_ready = 1'b0;
    for (int i = 0; i < 6; i++) put(8'ha0 + 8'(i));
    cyc(6);
    check_eq("fl_pre_occ", 32'(occ), 32'd2);
    flush = 1'b1;
    cyc(1);
    check_eq("fl_valid_low", 32'(sif.m_valid), 32'd0);
    cyc(5);
    flush = 1'b0;
    check_eq("fl_drop_count", 32'(drop_count), 32'd4);
    check_eq("fl_fifo_empty", 32'(fq.size()), 32'd0);
    check_eq("fl_occ", 32'(occ), 32'd0);
    exp_q.delete();
    sif.m_ready = 1'b1;
    put(8'h55);
    cyc(5);
    check_eq("post_fl_drained", 32'(exp_q.size()), 32'd0);
    check_eq("post_fl_rd_count", 32'(rd_count), 32'd26);

    // Narrow counters: wrap of rd_count, saturation of drop_count
    fifo_rempty4 = 1'b0;
    n4 = 0;
    for (int i = 0; i < 60 && n4 < 17; i++) begin
      @(negedge rclk);
      if (fifo_rinc4) n4++;
    end
    @(posedge rclk);
    #1;
    fifo_rempty4 = 1'b1;
    check_eq("cnt4_pops", n4, 32'd17);
    cyc(5);
    check_eq("cnt4_handshakes", hs4, 32'd17);
    check_eq("cnt4_rd_wrap", 32'(rd_count4), 32'd1);
    flush4 = 1'b1;
    fifo_rempty4 = 1'b0;
    n4 = 0;
    for (int i = 0; i < 60 && n4 < 20; i++) begin
      @(negedge rclk);
      if (fifo_rinc4) n4++;
    end
    @(posedge rclk);
    #1;
    fifo_rempty4 = 1'b1;
    flush4 = 1'b0;
    check_eq("cnt4_flush_pops", n4, 32'd20);
    cyc(2);
    check_eq("cnt4_drop_sat", 32'(drop_count4), 32'd15);
    check_eq("cnt4_rd_hold", 32'(rd_count4), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Read-side consumer for the dual-clock fifo (DSIZE/ASIZE). Lives entirely in the rclk domain.
- Drives the fifo's rinc from its rempty/rdata port and repackages words onto a valid/ready output stream.
- Holds words in a registered 2-entry skid buffer so the downstream can stall without losing data.
- Provides a flush (drain-and-discard) mode plus delivered/dropped word counters.

Parameters:
- DSIZE, 8, data word width; must match the fifo DSIZE.
- CNT_W, 16, width of the delivered and dropped word counters.

Ports:
- rclk  input  1  read-domain clock; all logic on rising edge.
- rrst_n  input  1  asynchronous active-low reset.
- fifo_rdata  input  DSIZE  fifo read data; first-word-fall-through, valid whenever fifo_rempty=0.
- fifo_rempty  input  1  fifo empty flag, registered in rclk domain.
- fifo_rinc  output  1  pop strobe to the fifo; combinational.
- m_data  output  DSIZE  output stream data (registered).
- m_valid  output  1  output stream valid (registered).
- m_ready  input  1  downstream ready.
- flush  input  1  level; while high, fifo words are popped and discarded.
- occ  output  2  skid-buffer occupancy, 0..2.
- rd_count  output  CNT_W  words accepted downstream (m_valid & m_ready); wraps modulo 2^CNT_W.
- drop_count  output  CNT_W  words discarded under flush; saturates at all-ones.

Behaviour:
- Reset (async assert, sync release):
  - State = EMPTY; occ=0; m_valid=0; m_data=0; rd_count=0; drop_count=0; buffer entries cleared.
  - While rrst_n=0, fifo_rinc=0.
- Definitions: pop_out = m_valid & m_ready; push = fifo_rinc & ~flush.
- fifo_rinc:
  - Normal mode: fifo_rinc = ~fifo_rempty & (occ<2).
  - Flush mode: fifo_rinc = ~fifo_rempty.
  - Never asserted when fifo_rempty=1.
- Buffer: head register (drives m_data) plus one skid register. Words leave in fifo order. No reordering, duplication or loss outside flush.
- State machine (state encodes occ):
  - EMPTY: push -> ONE, fifo_rdata loaded into head. No push -> stay.
  - ONE:
    - push & pop_out -> ONE, head <= fifo_rdata.
    - push only -> TWO, skid <= fifo_rdata.
    - pop_out only -> EMPTY.
  - TWO: no push possible (occ=2 blocks fifo_rinc). pop_out -> ONE, head <= skid.
  - Any state with flush=1 -> EMPTY on the next edge. Buffer contents are discarded (not counted in drop_count), m_valid=0 from the next cycle.
- Flush precedence:
  - flush beats pop_out in the same cycle. A word handshaken on the cycle flush is high is still counted in rd_count and is considered delivered.
  - Each fifo_rinc under flush increments drop_count by 1 (saturating).
- m_valid = (occ!=0), registered. m_valid stays high and m_data stays stable until pop_out (standard valid/ready rule). m_valid never depends combinationally on m_ready.
- Latency:
  - fifo_rempty falls at edge N, buffer empty -> fifo_rinc high in cycle N, m_valid/m_data valid after edge N+1.
  - Sustained throughput is 1 word/cycle when m_ready=1 and the fifo is non-empty.
- Boundaries:
  - fifo_rempty=1 with occ=1 and m_ready=1 -> EMPTY, m_valid drops next cycle.
  - m_ready=0 for long stalls -> at most 2 words popped, then fifo_rinc=0 until space frees.
  - rd_count wraps from 2^CNT_W-1 to 0.
  - Reset mid-transfer drops buffered words; the fifo itself is reset independently via the same rrst_n.

Decomposition:
- Shared package: state encoding (EMPTY=2'd0, ONE=2'd1, TWO=2'd2) and the default DSIZE/CNT_W constants.
- One natural sub-module: sat_counter (parameterized width, inc, clear, saturate-enable), used for both counters. rd_count instantiates it with saturation disabled.

Test Plan:
- Reset: hold rrst_n=0 with fifo_rempty=0 -> fifo_rinc=0, m_valid=0, counters 0. Release -> fifo_rinc=1 within the same cycle.
- Streaming: fifo holds 0x01..0x0F, m_ready=1 -> m_data sequence 0x01..0x0F on consecutive cycles, rd_count=15, first m_valid one cycle after the first fifo_rinc.
- Backpressure: m_ready=0 with 5 words queued -> exactly 2 fifo_rinc pulses, occ=2, m_data=0x01 held. m_ready=1 -> 0x01..0x05 in order, none lost.
- Toggling m_ready: m_ready pattern 1,0,1,1,0 on words 0x10..0x14 -> output order preserved, m_data stable while m_valid & ~m_ready.
- Flush: occ=2 and 4 words in fifo, flush high 6 cycles -> m_valid low next cycle, drop_count=4, fifo empty. After flush drops, new word 0x55 is delivered normally.
- Counter edge: CNT_W=4, deliver 17 words -> rd_count=1. Flush 20 words -> drop_count=15 (saturated).
